// File: rtl/bai1_sweep_ctrl.sv
// bai1_sweep_ctrl
// Walks a 3-input combinational block through all eight input vectors,
// lets each vector settle for SETTLE_CYCLES cycles, samples the block output
// into a truth table and compares it against a latched expected table.
// Vector order: c=1 half first (steps 0..3), then c=0 half (steps 4..7).
//
// Optional feature: define BAI1_SWEEP_ERRLOG_EN to add a first-failure log
// (o_fail_valid, o_first_fail_idx).
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_rst            synchronous active-high reset
//   i_start          sweep request, accepted only in IDLE
//   i_expected[7:0]  expected truth table, bit k for {c,b,a}=k
//   i_dut_out        output of the block under control
//   o_a/o_b/o_c      registered drive to the block inputs
//   o_busy           high while settling/sampling
//   o_done           one-cycle pulse when the sweep completes
//   o_tt[7:0]        captured truth table
//   o_mismatch_cnt   number of captured bits differing from expected
//   o_pass           mismatch_cnt==0, valid from done until next start
//   o_fail_valid     (errlog) a mismatch has been seen in this sweep
//   o_first_fail_idx (errlog) {c,b,a} of the first mismatch
module bai1_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_expected,
  input  logic       i_dut_out,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_tt,
  output logic [3:0] o_mismatch_cnt,
  output logic       o_pass
`ifdef BAI1_SWEEP_ERRLOG_EN
  ,
  output logic       o_fail_valid,
  output logic [2:0] o_first_fail_idx
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_param_check
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_step;
  logic [3:0] r_cnt;
  logic [7:0] r_expected;
  logic       r_a;
  logic       r_b;
  logic       r_c;
  logic [7:0] r_tt;
  logic [3:0] r_mm_cnt;
  logic       r_pass;

  logic [2:0] w_idx;
  logic       w_miss;
  logic [3:0] w_mm_next;
  logic [2:0] w_next_step;

  // The truth-table index is the vector currently on the pins, not the step.
  assign w_idx       = {r_c, r_b, r_a};
  assign w_miss      = (i_dut_out != r_expected[w_idx]);
  assign w_mm_next   = r_mm_cnt + {3'b000, w_miss};
  assign w_next_step = r_step + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        o_busy = 1'b1;
        if (r_cnt == LP_SETTLE_LAST) begin
          w_state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        o_busy       = 1'b1;
        w_state_next = (r_step == 3'd7) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath. a/b/c are loaded with the next vector on the same edge that
  // enters SETTLE, so the settle window sees a stable vector from its first cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step     <= 3'd0;
      r_cnt      <= 4'd0;
      r_expected <= 8'd0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_c        <= 1'b0;
      r_tt       <= 8'd0;
      r_mm_cnt   <= 4'd0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_expected <= i_expected;
            r_tt       <= 8'd0;
            r_mm_cnt   <= 4'd0;
            r_pass     <= 1'b0;
            r_step     <= 3'd0;
            r_cnt      <= 4'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_c        <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt != LP_SETTLE_LAST) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          r_tt[w_idx] <= i_dut_out;
          r_mm_cnt    <= w_mm_next;
          if (r_step == 3'd7) begin
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_c    <= 1'b0;
            r_pass <= (w_mm_next == 4'd0);
          end else begin
            r_step <= w_next_step;
            r_cnt  <= 4'd0;
            r_a    <= w_next_step[0];
            r_b    <= w_next_step[1];
            r_c    <= ~w_next_step[2];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BAI1_SWEEP_ERRLOG_EN
  logic       r_fail_valid;
  logic [2:0] r_first_fail_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fail_valid     <= 1'b0;
      r_first_fail_idx <= 3'd0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_fail_valid     <= 1'b0;
      r_first_fail_idx <= 3'd0;
    end else if (r_state == ST_SAMPLE && w_miss && !r_fail_valid) begin
      // Only the first mismatch of a sweep is recorded.
      r_fail_valid     <= 1'b1;
      r_first_fail_idx <= w_idx;
    end
  end

  assign o_fail_valid     = r_fail_valid;
  assign o_first_fail_idx = r_first_fail_idx;
`endif

  assign o_a            = r_a;
  assign o_b            = r_b;
  assign o_c            = r_c;
  assign o_tt           = r_tt;
  assign o_mismatch_cnt = r_mm_cnt;
  assign o_pass         = r_pass;

endmodule

// File: doc/bai1_sweep_ctrl.md
BAI1_SWEEP_CTRL -- requirements
Module: bai1_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of settle cycles per input vector before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 expected  input  8  expected truth table, bit k = expected Out for {c,b,a}=k; latched on start acceptance.
REQ-006 dut_out  input  1  Out of the 3-input combinational block under control.
REQ-007 a, b, c  output  1 each  registered drive to the block inputs.
REQ-008 busy  output  1  high from the cycle after start acceptance through the final SAMPLE cycle.
REQ-009 done  output  1  one-cycle pulse in the DONE state.
REQ-010 tt  output  8  captured truth table, bit k = sampled dut_out for {c,b,a}=k.
REQ-011 mismatch_cnt  output  4  count of tt bits differing from latched expected (0..8).
REQ-012 pass  output  1  high when mismatch_cnt==0; valid from done, held until next start acceptance.

Function
REQ-013 The block SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE & start SHALL go to SETTLE, clear tt/mismatch_cnt/pass, latch expected, set step=0, settle counter=0.
REQ-015 Step i (0..7) SHALL drive a=i[0], b=i[1], c=~i[2] (c=1 half first, then c=0 half).
REQ-016 SETTLE SHALL hold a/b/c for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL write dut_out into tt[{c,b,a}] and add 1 to mismatch_cnt if it differs from expected[{c,b,a}].
REQ-018 SAMPLE with step<7 SHALL increment step and return to SETTLE with the counter cleared; step==7 SHALL go to DONE.
REQ-019 DONE SHALL last one cycle with done=1, pass valid, then go to IDLE.
REQ-020 Latency: start accepted at cycle 0 -> done at cycle 1+8*(SETTLE_CYCLES+1); 25 for default.
REQ-021 start outside IDLE (including the DONE cycle) SHALL be ignored, no queuing.
REQ-022 a/b/c SHALL be 0 in IDLE and DONE.
REQ-023 tt, mismatch_cnt, pass SHALL hold their values in IDLE until the next start acceptance.

Reset
REQ-024 rst SHALL take priority over all other inputs, including mid-sweep.
REQ-025 After rst: state=IDLE, a=b=c=0, busy=0, done=0, tt=0, mismatch_cnt=0, pass=0, step=0, counter=0.
REQ-026 A sweep aborted by rst SHALL NOT produce done.

Configuration
REQ-027 Macro BAI1_SWEEP_ERRLOG_EN, when defined, SHALL add outputs fail_valid(1) and first_fail_idx(3).
REQ-028 With the macro: on the first mismatching SAMPLE of a sweep, fail_valid=1 and first_fail_idx={c,b,a}; both SHALL clear on start acceptance and rst.
REQ-029 Without the macro those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Model dut_out=(a&b)|c, expected=8'hF8, start at cycle 0 -> done at cycle 25, tt=F8, mismatch_cnt=0, pass=1.
REQ-031 Same model, expected=8'hF9 -> tt=F8, mismatch_cnt=1, pass=0; with errlog, fail_valid=1, first_fail_idx=0 (sweep step 4).
REQ-032 dut_out tied 0, expected=8'hFF -> mismatch_cnt=8, pass=0; with errlog, first_fail_idx=4 (step 0).
REQ-033 start pulsed at cycles 5 and 25 during a sweep -> ignored; single done at cycle 25; a/b/c sequence unaltered.
REQ-034 rst at cycle 10 mid-sweep -> next cycle all outputs at reset values, no done; new start then completes normally.
REQ-035 SETTLE_CYCLES=1, start -> each vector held 1 cycle plus sample cycle; done at cycle 17.
